usb_buffer_arbiter: RTL and testbench

USB_BUFFER_ARBITER -- requirements
Module: usb_buffer_arbiter

---
 rtl/usb_buffer_pkg.sv | 21 ++
 rtl/usb_buffer_arbiter_if.sv | 45 ++++
 rtl/usb_arb_timeout_counter.sv | 24 ++
 rtl/usb_buffer_arbiter.sv | 151 +++++++++++++++
 tb/tb_usb_buffer_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared types and constants for the USB buffer arbiter.
// Holds the FSM state enum, the 3-bit mode encodings and the default DEPTH.
package usb_buffer_pkg;
    localparam int DEPTH_DEF = 64;

    localparam logic [2:0] MODE_IDLE     = 3'd0;
    localparam logic [2:0] MODE_TX_FILL  = 3'd1;
    localparam logic [2:0] MODE_TX_SEND  = 3'd2;
    localparam logic [2:0] MODE_RX_FILL  = 3'd3;
    localparam logic [2:0] MODE_RX_DRAIN = 3'd4;
    localparam logic [2:0] MODE_FLUSH    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = MODE_IDLE,
        ST_TX_FILL  = MODE_TX_FILL,
        ST_TX_SEND  = MODE_TX_SEND,
        ST_RX_FILL  = MODE_RX_FILL,
        ST_RX_DRAIN = MODE_RX_DRAIN,
        ST_FLUSH    = MODE_FLUSH
    } state_e;
endpackage

// File: rtl/usb_buffer_arbiter_if.sv
// Bus between the arbiter and its environment (host, USB TX/RX engines, buffer).
// master = arbiter side, slave = environment side.
interface usb_buffer_arbiter_if;
    logic       host_wr_req;
    logic [7:0] host_wr_data;
    logic       host_rd_req;
    logic       host_flush;
    logic       tx_get_req;
    logic       tx_packet_done;
    logic       rx_put_req;
    logic [7:0] rx_put_data;
    logic       rx_packet_done;
    logic [6:0] Buffer_Occupancy;

    logic       Store_TX_Data;
    logic       Store_RX_Packet_Data;
    logic       Get_TX_Packet_Data;
    logic       Get_RX_Data;
    logic [7:0] TX_Data;
    logic [7:0] RX_Packet_Data;
    logic       flush;
    logic       host_grant;
    logic       usb_grant;
    logic [2:0] mode;
    logic       err;
    logic [3:0] err_count;

    modport master (
        input  host_wr_req, host_wr_data, host_rd_req, host_flush,
               tx_get_req, tx_packet_done, rx_put_req, rx_put_data,
               rx_packet_done, Buffer_Occupancy,
        output Store_TX_Data, Store_RX_Packet_Data, Get_TX_Packet_Data,
               Get_RX_Data, TX_Data, RX_Packet_Data, flush, host_grant,
               usb_grant, mode, err, err_count
    );

    modport slave (
        output host_wr_req, host_wr_data, host_rd_req, host_flush,
               tx_get_req, tx_packet_done, rx_put_req, rx_put_data,
               rx_packet_done, Buffer_Occupancy,
        input  Store_TX_Data, Store_RX_Packet_Data, Get_TX_Packet_Data,
               Get_RX_Data, TX_Data, RX_Packet_Data, flush, host_grant,
               usb_grant, mode, err, err_count
    );
endinterface

// File: rtl/usb_arb_timeout_counter.sv
// Idle-cycle counter for the arbiter's stall timeout.
// expire is high in the TIMEOUT-th consecutive enabled cycle; clear wins over enable.
module usb_arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    assign o_expire = i_enable && (r_cnt == W'(TIMEOUT - 1));

    // Count consecutive idle cycles, restart on clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          r_cnt <= '0;
        else if (i_clear)    r_cnt <= '0;
        else if (i_enable)   r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/usb_buffer_arbiter.sv
// USB buffer arbiter: steers one shared byte buffer between host and USB engines.
// Strobes/grants are combinational from state and inputs; state, err, err_count registered.
// Optional stall timeout in TX_SEND / RX_FILL: define USB_BUF_ARB_TIMEOUT_EN.
module usb_buffer_arbiter
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_buffer_arbiter_if.master  bus
);
    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    state_e     r_state;
    state_e     w_next;
    logic       r_err;
    logic [3:0] r_err_count;

    logic       w_full, w_empty;
    logic       w_st_tx, w_st_rx, w_get_tx, w_get_rx;
    logic [7:0] w_tx_data, w_rx_data;
    logic       w_host_grant, w_usb_grant;
    logic       w_refuse;
    logic       w_expire;

    assign w_full  = (bus.Buffer_Occupancy >= DEPTH_W);
    assign w_empty = (bus.Buffer_Occupancy == 7'd0);

    // Per-state grant/strobe decode and next-state selection
    always_comb begin
        w_next       = r_state;
        w_st_tx      = 1'b0;
        w_st_rx      = 1'b0;
        w_get_tx     = 1'b0;
        w_get_rx     = 1'b0;
        w_tx_data    = 8'h00;
        w_rx_data    = 8'h00;
        w_host_grant = 1'b0;
        w_usb_grant  = 1'b0;
        w_refuse     = 1'b0;
        if (bus.host_flush) begin
            // abort beats everything and issues no strobe
            w_next = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_put_req)       w_next = ST_RX_FILL;
                    else if (bus.host_wr_req) w_next = ST_TX_FILL;
                end
                ST_TX_FILL: begin
                    if (bus.host_wr_req) begin
                        if (!w_full) begin
                            w_st_tx      = 1'b1;
                            w_tx_data    = bus.host_wr_data;
                            w_host_grant = 1'b1;
                        end else begin
                            w_refuse = 1'b1;
                        end
                    end
                    if (bus.tx_get_req) w_next = ST_TX_SEND;
                end
                ST_TX_SEND: begin
                    if (bus.tx_get_req) begin
                        if (!w_empty) begin
                            w_get_tx    = 1'b1;
                            w_usb_grant = 1'b1;
                        end else begin
                            w_refuse = 1'b1;
                        end
                    end
                    if (bus.tx_packet_done || w_expire) w_next = ST_FLUSH;
                end
                ST_RX_FILL: begin
                    if (bus.rx_put_req) begin
                        if (!w_full) begin
                            w_st_rx     = 1'b1;
                            w_rx_data   = bus.rx_put_data;
                            w_usb_grant = 1'b1;
                        end else begin
                            w_refuse = 1'b1;
                        end
                    end
                    if (w_expire)                w_next = ST_FLUSH;
                    else if (bus.rx_packet_done) w_next = ST_RX_DRAIN;
                end
                ST_RX_DRAIN: begin
                    if (bus.host_rd_req) begin
                        if (!w_empty) begin
                            w_get_rx     = 1'b1;
                            w_host_grant = 1'b1;
                        end else begin
                            w_refuse = 1'b1;
                        end
                    end else if (w_empty) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_FLUSH: w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

`ifdef USB_BUF_ARB_TIMEOUT_EN
    logic w_to_en, w_to_clr;

    // idle cycles only accrue in the two states that wait on the USB engine
    assign w_to_en  = (r_state == ST_TX_SEND || r_state == ST_RX_FILL) &&
                      !w_usb_grant && !bus.host_flush;
    assign w_to_clr = w_usb_grant || (w_next != r_state);

    usb_arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_clear  (w_to_clr),
        .i_enable (w_to_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // State register plus error pulse and saturating error count
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_err       <= 1'b0;
            r_err_count <= 4'd0;
        end else begin
            r_state <= w_next;
            r_err   <= w_refuse || w_expire;
            if ((w_refuse || w_expire) && r_err_count != 4'hF)
                r_err_count <= r_err_count + 4'd1;
        end
    end

    assign bus.Store_TX_Data        = w_st_tx;
    assign bus.Store_RX_Packet_Data = w_st_rx;
    assign bus.Get_TX_Packet_Data   = w_get_tx;
    assign bus.Get_RX_Data          = w_get_rx;
    assign bus.TX_Data              = w_tx_data;
    assign bus.RX_Packet_Data       = w_rx_data;
    assign bus.host_grant           = w_host_grant;
    assign bus.usb_grant            = w_usb_grant;
    assign bus.flush                = (r_state == ST_FLUSH);
    assign bus.mode                 = r_state;
    assign bus.err                  = r_err;
    assign bus.err_count            = r_err_count;
endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled on the falling edge.
// Builds with or without USB_BUF_ARB_TIMEOUT_EN; the DUT is built with TIMEOUT=4.
module tb_usb_buffer_arbiter;
    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_bad;

    usb_buffer_arbiter_if bus();

    usb_buffer_arbiter #(.DEPTH(64), .TIMEOUT(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({bus.Store_TX_Data, bus.Store_RX_Packet_Data,
                    bus.Get_TX_Packet_Data, bus.Get_RX_Data});
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_rst = 1'b0;
        bus.host_wr_req = 1'b1;  bus.host_wr_data = 8'h00;
        bus.host_rd_req = 1'b0;  bus.host_flush = 1'b0;
        bus.tx_get_req = 1'b0;   bus.tx_packet_done = 1'b0;
        bus.rx_put_req = 1'b1;   bus.rx_put_data = 8'h00;
        bus.rx_packet_done = 1'b0;
        bus.Buffer_Occupancy = 7'd0;

        // reset holds IDLE with everything quiet even while requests are up
        repeat (3) @(negedge clk);
        chk("rst_mode",    32'(bus.mode), 0);
        chk("rst_err",     32'(bus.err), 0);
        chk("rst_errcnt",  32'(bus.err_count), 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_grants",  32'({bus.host_grant, bus.usb_grant}), 0);
        chk("rst_flush",   32'(bus.flush), 0);
        bus.host_wr_req = 1'b0;
        bus.rx_put_req  = 1'b0;
        n_rst = 1'b1;
        step();

        // TX path: 3 writes, 3 gets, done -> FLUSH -> IDLE
        bus.host_wr_req = 1'b1; bus.host_wr_data = 8'hA1;
        @(negedge clk);
        chk("idle_no_grant", 32'(bus.host_grant), 0);
        chk("idle_no_store", 32'(bus.Store_TX_Data), 0);
        step();
        chk("tx_fill_mode", 32'(bus.mode), 1);
        for (int i = 0; i < 3; i++) begin
            bus.host_wr_data = 8'hA1 + 8'(i);
            @(negedge clk);
            chk("tx_store", 32'(bus.Store_TX_Data), 1);
            chk("tx_data",  32'(bus.TX_Data), 32'(8'hA1 + 8'(i)));
            chk("tx_hgrant", 32'(bus.host_grant), 1);
            step();
            bus.Buffer_Occupancy = 7'(i + 1);
        end
        bus.host_wr_req = 1'b0;
        bus.tx_get_req  = 1'b1;
        @(negedge clk);
        chk("tx_data_zero",  32'(bus.TX_Data), 0);
        chk("get_in_fill",   32'(bus.Get_TX_Packet_Data), 0);
        chk("ugrant_in_fill", 32'(bus.usb_grant), 0);
        step();
        chk("tx_send_mode", 32'(bus.mode), 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tx_get", 32'(bus.Get_TX_Packet_Data), 1);
            chk("tx_ugrant", 32'(bus.usb_grant), 1);
            step();
            bus.Buffer_Occupancy = 7'(2 - i);
        end
        bus.tx_get_req = 1'b0;
        bus.tx_packet_done = 1'b1;
        step();
        bus.tx_packet_done = 1'b0;
        chk("tx_flush_mode", 32'(bus.mode), 5);
        chk("tx_flush_pulse", 32'(bus.flush), 1);
        chk("tx_flush_strobes", strobes(), 0);
        step();
        chk("tx_back_idle", 32'(bus.mode), 0);
        chk("tx_flush_gone", 32'(bus.flush), 0);

        // RX wins over host write in IDLE
        bus.rx_put_req = 1'b1; bus.host_wr_req = 1'b1;
        @(negedge clk);
        chk("both_hgrant", 32'(bus.host_grant), 0);
        chk("both_ugrant", 32'(bus.usb_grant), 0);
        step();
        bus.host_wr_req = 1'b0;
        chk("both_rx_mode", 32'(bus.mode), 3);

        // RX put granted, then refused at full
        bus.Buffer_Occupancy = 7'd5; bus.rx_put_data = 8'h5C;
        @(negedge clk);
        chk("rx_store", 32'(bus.Store_RX_Packet_Data), 1);
        chk("rx_data",  32'(bus.RX_Packet_Data), 32'h5C);
        chk("rx_ugrant", 32'(bus.usb_grant), 1);
        step();
        chk("rx_no_err", 32'(bus.err), 0);
        bus.Buffer_Occupancy = 7'd64; bus.rx_put_data = 8'h77;
        @(negedge clk);
        chk("full_ugrant", 32'(bus.usb_grant), 0);
        chk("full_store",  32'(bus.Store_RX_Packet_Data), 0);
        chk("full_data",   32'(bus.RX_Packet_Data), 0);
        step();
        chk("full_err",    32'(bus.err), 1);
        chk("full_errcnt", 32'(bus.err_count), 1);
        bus.rx_put_req = 1'b0;
        bus.rx_packet_done = 1'b1;
        step();
        bus.rx_packet_done = 1'b0;
        chk("err_one_cycle", 32'(bus.err), 0);
        chk("rx_drain_mode", 32'(bus.mode), 4);

        // host_flush in RX_DRAIN at occupancy 10
        bus.Buffer_Occupancy = 7'd10; bus.host_rd_req = 1'b1;
        @(negedge clk);
        chk("drain_get", 32'(bus.Get_RX_Data), 1);
        bus.host_flush = 1'b1;
        #1;
        chk("hflush_no_get",   32'(bus.Get_RX_Data), 0);
        chk("hflush_no_grant", 32'(bus.host_grant), 0);
        step();
        bus.host_flush = 1'b0; bus.host_rd_req = 1'b0;
        chk("hflush_mode",  32'(bus.mode), 5);
        chk("hflush_pulse", 32'(bus.flush), 1);
        step();
        chk("hflush_idle", 32'(bus.mode), 0);

        // 16 refused reads saturate err_count; a read in RX_FILL is just ignored
        bus.Buffer_Occupancy = 7'd0; bus.rx_put_req = 1'b1;
        step();
        bus.rx_put_req = 1'b0; bus.host_rd_req = 1'b1; bus.rx_packet_done = 1'b1;
        step();
        bus.rx_packet_done = 1'b0;
        chk("mismatch_no_err", 32'(bus.err), 0);
        chk("sat_drain_mode",  32'(bus.mode), 4);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("empty_get", 32'(bus.Get_RX_Data), 0);
            step();
            chk("empty_err", 32'(bus.err), 1);
            chk("sat_errcnt", 32'(bus.err_count), (i + 2 > 15) ? 15 : i + 2);
        end
        bus.host_rd_req = 1'b0;
        step();
        chk("drain_exit_idle", 32'(bus.mode), 0);
        chk("drain_exit_err",  32'(bus.err), 0);

        // TX_SEND with no gets
        bus.host_wr_req = 1'b1;
        step();
        bus.host_wr_req = 1'b0; bus.tx_get_req = 1'b1;
        bus.Buffer_Occupancy = 7'd1;
        step();
        bus.tx_get_req = 1'b0;
        chk("stall_send_mode", 32'(bus.mode), 2);
`ifdef USB_BUF_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_mode", 32'(bus.mode), 2);
            chk("to_wait_err",  32'(bus.err), 0);
        end
        step();
        chk("to_flush_mode", 32'(bus.mode), 5);
        chk("to_err",        32'(bus.err), 1);
        chk("to_errcnt",     32'(bus.err_count), 15);
        step();
        chk("to_idle", 32'(bus.mode), 0);
        chk("to_err_gone", 32'(bus.err), 0);
`else
        repeat (8) step();
        chk("no_to_mode", 32'(bus.mode), 2);
        chk("no_to_err",  32'(bus.err), 0);
        bus.host_flush = 1'b1;
        step();
        bus.host_flush = 1'b0;
        chk("no_to_flush", 32'(bus.mode), 5);
        step();
        chk("no_to_idle", 32'(bus.mode), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
